// File: rtl/prog_loader.sv
// Program-memory loader: assembles framed 18-bit instructions from a byte stream,
// writes them to the instruction BRAM and holds the processor in reset until verified.
module prog_loader #(
  parameter logic [7:0]  START_BYTE = 8'hA5,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [9:0]  mem_address,
  output logic [17:0] mem_instruction,
  output logic [3:0]  mem_we,
  output logic        proc_reset,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_B2, S_B1, S_B0, S_WR, S_CHK
  } state_t;

  state_t      state_q, state_d;
  logic        rx_ready_q, rx_ready_d;
  logic [9:0]  addr_q, addr_d;
  logic [17:0] instr_q, instr_d;
  logic [3:0]  we_q, we_d;
  logic        proc_reset_q, proc_reset_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  chk_q, chk_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [1:0]  w2_q, w2_d;
  logic [7:0]  w1_q, w1_d;
  logic [15:0] tmo_q, tmo_d;
  logic        accept;

  assign accept = rx_valid & rx_ready_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    proc_reset_d = proc_reset_q;
    done_d       = 1'b0;
    err_d        = err_q;
    chk_d        = chk_q;
    cnt_d        = cnt_q;
    w2_d         = w2_q;
    w1_d         = w1_q;
    tmo_d        = 16'd0;

    case (state_q)
      S_IDLE: begin
        if (accept && rx_data == START_BYTE) begin
          proc_reset_d = 1'b1;
          err_d        = 1'b0;
          chk_d        = 8'h00;
          addr_d       = 10'd0;
          state_d      = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          chk_d = chk_q ^ rx_data;
          if (rx_data[7:2] != 6'd0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d[9:8] = rx_data[1:0];
            state_d    = S_LEN_LO;
          end
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          chk_d      = chk_q ^ rx_data;
          cnt_d[7:0] = rx_data;
          state_d    = S_B2;
        end
      end
      S_B2: begin
        if (accept) begin
          chk_d   = chk_q ^ rx_data;
          w2_d    = rx_data[1:0];
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (accept) begin
          chk_d   = chk_q ^ rx_data;
          w1_d    = rx_data;
          state_d = S_B0;
        end
      end
      S_B0: begin
        if (accept) begin
          chk_d   = chk_q ^ rx_data;
          instr_d = {w2_q, w1_q, rx_data};
          state_d = S_WR;
        end
      end
      S_WR: begin
        // cnt holds words remaining after this one; the final increment wraps harmlessly
        addr_d = addr_q + 10'd1;
        if (cnt_q == 10'd0) begin
          state_d = S_CHK;
        end else begin
          cnt_d   = cnt_q - 10'd1;
          state_d = S_B2;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (rx_data == chk_q) begin
            done_d       = 1'b1;
            proc_reset_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog; never fires on a cycle that consumed a byte
    if (state_q != S_IDLE && !accept) begin
      if (tmo_q == TIMEOUT - 16'd1) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end

    we_d       = (state_d == S_WR) ? 4'b1111 : 4'b0000;
    rx_ready_d = (state_d != S_WR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rx_ready_q   <= 1'b0;
      addr_q       <= 10'd0;
      instr_q      <= 18'd0;
      we_q         <= 4'b0000;
      proc_reset_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      chk_q        <= 8'h00;
      cnt_q        <= 10'd0;
      w2_q         <= 2'd0;
      w1_q         <= 8'h00;
      tmo_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      we_q         <= we_d;
      proc_reset_q <= proc_reset_d;
      done_q       <= done_d;
      err_q        <= err_d;
      chk_q        <= chk_d;
      cnt_q        <= cnt_d;
      w2_q         <= w2_d;
      w1_q         <= w1_d;
      tmo_q        <= tmo_d;
    end
  end

  assign rx_ready        = rx_ready_q;
  assign mem_address     = addr_q;
  assign mem_instruction = instr_q;
  assign mem_we          = we_q;
  assign proc_reset      = proc_reset_q;
  assign load_done       = done_q;
  assign load_error      = err_q;

endmodule
